// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous word store with a post-reset init sweep and a 1- or 2-stage registered read path.
// Optional feature macro: RAM_PARITY_EN (per-word even parity with a par_err pulse aligned to rvalid).
module sync_ram_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int RD_LAT    = 1,
    parameter int INIT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              addr_err,
`ifdef RAM_PARITY_EN
    output logic              par_err,
`endif
    output logic              init_done
);

    // Handshake: a request is taken on any rising edge where req && ready; ready is high only in IDLE.
    typedef enum logic {S_INIT, S_IDLE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] sweep_addr;
    logic              accept;
    logic              in_range;
    logic              last_sweep;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] init_val;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              s1_valid;
    logic              s1_err;
    logic [DATA_W-1:0] s1_data;

    assign accept     = req && ready;
    assign in_range   = 32'(addr) < DEPTH;
    assign last_sweep = 32'(sweep_addr) == DEPTH - 1;
    assign init_val   = (INIT_MODE == 1) ? DATA_W'(sweep_addr) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_INIT;
            sweep_addr <= '0;
            ready      <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            unique case (state)
                S_INIT: begin
                    if (last_sweep) begin
                        state     <= S_IDLE;
                        ready     <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                    end
                end
                S_IDLE: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    // The sweep owns the write port in INIT; out-of-range writes are dropped here.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr;
        mem_wdata = wdata;
        if (state == S_INIT) begin
            mem_we    = 1'b1;
            mem_addr  = sweep_addr;
            mem_wdata = init_val;
        end else if (accept && we && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept && !we;
            s1_err   <= accept && !in_range;
            if (accept && !we) begin
                s1_data <= in_range ? mem[addr] : '0;
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic par_mem [DEPTH];
    logic s1_perr;

    always @(posedge clk) begin
        if (mem_we) begin
            par_mem[mem_addr] <= ^mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_perr <= 1'b0;
        end else begin
            s1_perr <= accept && !we && in_range && ((^mem[addr]) != par_mem[addr]);
        end
    end

    task flip_parity(input logic [ADDR_W-1:0] a);
        par_mem[a] = ~par_mem[a];
    endtask
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_valid;
            logic              s2_err;
            logic [DATA_W-1:0] s2_data;
`ifdef RAM_PARITY_EN
            logic              s2_perr;
`endif
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_err   <= 1'b0;
                    s2_data  <= '0;
`ifdef RAM_PARITY_EN
                    s2_perr  <= 1'b0;
`endif
                end else begin
                    s2_valid <= s1_valid;
                    s2_err   <= s1_err;
`ifdef RAM_PARITY_EN
                    s2_perr  <= s1_perr;
`endif
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end
            assign rvalid   = s2_valid;
            assign addr_err = s2_err;
            assign rdata    = s2_data;
`ifdef RAM_PARITY_EN
            assign par_err  = s2_perr;
`endif
        end else begin : g_lat1
            assign rvalid   = s1_valid;
            assign addr_err = s1_err;
            assign rdata    = s1_data;
`ifdef RAM_PARITY_EN
            assign par_err  = s1_perr;
`endif
        end
    endgenerate

endmodule
